// File: rtl/ks_multiword_sequencer_if.sv
// Operand/result handshake and word-adder port bundle for ks_multiword_sequencer.
// The sub line exists only when KS_SEQ_SUB_EN is defined.
interface ks_multiword_sequencer_if #(
  parameter int WORD_W = 32,
  parameter int NWORDS = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [WORD_W*NWORDS-1:0] a_in;
  logic [WORD_W*NWORDS-1:0] b_in;
  logic                     cin;
`ifdef KS_SEQ_SUB_EN
  logic                     sub;
`endif
  logic                     out_valid;
  logic                     out_ready;
  logic [WORD_W*NWORDS-1:0] sum_out;
  logic                     cout_out;
  logic [WORD_W-1:0]        add_a;
  logic [WORD_W-1:0]        add_b;
  logic                     add_cin;
  logic [WORD_W-1:0]        add_sum;
  logic                     add_cout;

  modport master (
`ifdef KS_SEQ_SUB_EN
    output sub,
`endif
    output in_valid, a_in, b_in, cin, out_ready, add_sum, add_cout,
    input  in_ready, out_valid, sum_out, cout_out, add_a, add_b, add_cin
  );

  modport slave (
`ifdef KS_SEQ_SUB_EN
    input  sub,
`endif
    input  in_valid, a_in, b_in, cin, out_ready, add_sum, add_cout,
    output in_ready, out_valid, sum_out, cout_out, add_a, add_b, add_cin
  );
endinterface

// File: rtl/ks_multiword_sequencer.sv
// Wide add (A-B too when KS_SEQ_SUB_EN is defined) on one registered word adder, LSW first, with the carry chained.
// Latency NWORDS+2 from accept to out_valid; one op in flight, in_ready low until the result is taken.
module ks_multiword_sequencer #(
  parameter int WORD_W = 32,
  parameter int NWORDS = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  ks_multiword_sequencer_if.slave  bus
);
  localparam int CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CW-1:0] KLAST = CW'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                         state, state_nxt;
  logic [NWORDS-1:0][WORD_W-1:0]  a_q, b_q, sum_q;
  logic                           cin_q, sub_q, cout_q;
  logic [CW-1:0]                  k, m;
  logic                           sub_in;

`ifdef KS_SEQ_SUB_EN
  assign sub_in = bus.sub;
`else
  assign sub_in = 1'b0;
`endif

  assign bus.sum_out  = sum_q;
  assign bus.cout_out = cout_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.add_a     = '0;
    bus.add_b     = '0;
    bus.add_cin   = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        bus.add_a = a_q[k];
        bus.add_b = sub_q ? ~b_q[k] : b_q[k];
        // Word 0 never looks at the adder's cout, so a leftover carry cannot leak in.
        bus.add_cin = (k == '0) ? (sub_q | cin_q) : bus.add_cout;
        if (k == KLAST) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q    <= '0;
      b_q    <= '0;
      cin_q  <= 1'b0;
      sub_q  <= 1'b0;
      k      <= '0;
      m      <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q    <= bus.a_in;
            b_q    <= bus.b_in;
            cin_q  <= bus.cin;
            sub_q  <= sub_in;
            k      <= '0;
            m      <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
          end
        end
        ISSUE: begin
          if (k != KLAST) k <= k + 1'b1;
          // The adder output lags issue by one cycle: word k-1 lands while word k goes out.
          if (k != '0) begin
            sum_q[m] <= bus.add_sum;
            m        <= m + 1'b1;
          end
        end
        DRAIN: begin
          sum_q[m] <= bus.add_sum;
          cout_q   <= bus.add_cout;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ks_multiword_sequencer.sv
// Bench for ks_multiword_sequencer: 8x4 and 8x1 instances with registered word-adder models,
// directed cases plus random operands checked against whole-width arithmetic.
module tb_ks_multiword_sequencer;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int TW = W * N;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [TW-1:0] ra, rb;
  logic          rci, rsb, seen;
  logic [TW:0]   rr;
  logic [W-1:0]  sa, sb8;
  logic [W:0]    sr;

  always #5 clk = ~clk;

  ks_multiword_sequencer_if #(.WORD_W(W), .NWORDS(N)) bus0 ();
  ks_multiword_sequencer_if #(.WORD_W(W), .NWORDS(1)) bus1 ();

  ks_multiword_sequencer #(.WORD_W(W), .NWORDS(N)) dut0 (.clk(clk), .resetn(resetn), .bus(bus0));
  ks_multiword_sequencer #(.WORD_W(W), .NWORDS(1)) dut1 (.clk(clk), .resetn(resetn), .bus(bus1));

  // Registered word adders, reset by the same resetn as the sequencers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus0.add_sum  <= '0;
      bus0.add_cout <= 1'b0;
      bus1.add_sum  <= '0;
      bus1.add_cout <= 1'b0;
    end else begin
      {bus0.add_cout, bus0.add_sum} <= {1'b0, bus0.add_a} + {1'b0, bus0.add_b} + (W+1)'(bus0.add_cin);
      {bus1.add_cout, bus1.add_sum} <= {1'b0, bus1.add_a} + {1'b0, bus1.add_b} + (W+1)'(bus1.add_cin);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TW:0] ref_add(input logic [TW-1:0] a, b, input logic ci, sb);
    logic [TW-1:0] bt;
    logic          c;
    bt = sb ? ~b : b;
    c  = sb | ci;
    return {1'b0, a} + {1'b0, bt} + (TW+1)'(c);
  endfunction

  // Carry into word k = carry out of the low k words of the full-width sum.
  function automatic logic [N-1:0] ref_cins(input logic [TW-1:0] a, b, input logic ci, sb);
    logic [TW-1:0] bt;
    logic [63:0]   mask, s;
    logic          c;
    logic [N-1:0]  r;
    bt = sb ? ~b : b;
    c  = sb | ci;
    for (int k = 0; k < N; k++) begin
      mask = (64'd1 << (k * W)) - 64'd1;
      s    = (64'(a) & mask) + (64'(bt) & mask) + 64'(c);
      r[k] = s[k * W];
    end
    return r;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, bus0.in_ready, 1'b1);
    check({tag, "_out_valid"}, bus0.out_valid, 1'b0);
    check({tag, "_sum"}, bus0.sum_out, '0);
    check({tag, "_cout"}, bus0.cout_out, 1'b0);
    check({tag, "_adder_port"}, {bus0.add_a, bus0.add_b, bus0.add_cin}, '0);
  endtask

  task automatic run_op(input logic [TW-1:0] a, b, input logic ci, sb,
                        input logic [TW-1:0] exp_sum, input logic exp_cout,
                        input logic [N-1:0] exp_cins, input int hold);
    int           n;
    int           lat;
    logic [N-1:0] cins;
    n = 0;
    @(negedge clk);
    while (!bus0.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", bus0.in_ready, 1'b1);
    bus0.in_valid = 1'b1;
    bus0.a_in     = a;
    bus0.b_in     = b;
    bus0.cin      = ci;
`ifdef KS_SEQ_SUB_EN
    bus0.sub      = sb;
`else
    if (sb) $display("note: sub requested without KS_SEQ_SUB_EN");
`endif
    @(negedge clk);
    lat  = 1;
    cins = '0;
    while (!bus0.out_valid && lat < N + 8) begin
      if (lat <= N) cins[lat-1] = bus0.add_cin;
      check("busy_in_ready", bus0.in_ready, 1'b0);
      // Busy-time requests and operand churn must be ignored.
      bus0.in_valid = 1'($urandom);
      bus0.a_in     = $urandom;
      bus0.b_in     = $urandom;
      bus0.cin      = 1'($urandom);
`ifdef KS_SEQ_SUB_EN
      bus0.sub      = 1'($urandom);
`endif
      @(negedge clk);
      lat++;
    end
    check("latency", lat, N + 2);
    check("sum", bus0.sum_out, exp_sum);
    check("cout", bus0.cout_out, exp_cout);
    check("add_cin_seq", cins, exp_cins);
    check("adder_idle", {bus0.add_a, bus0.add_b, bus0.add_cin}, '0);
    for (int i = 0; i < hold; i++) begin
      bus0.in_valid = 1'b1;
      bus0.a_in     = $urandom;
      @(negedge clk);
      check("hold_valid", bus0.out_valid, 1'b1);
      check("hold_sum", bus0.sum_out, exp_sum);
      check("hold_cout", bus0.cout_out, exp_cout);
      check("hold_in_ready", bus0.in_ready, 1'b0);
    end
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b1;
    @(negedge clk);
    bus0.out_ready = 1'b0;
    check("post_valid", bus0.out_valid, 1'b0);
    check("post_in_ready", bus0.in_ready, 1'b1);
  endtask

  task automatic run1(input logic [W-1:0] a, b, input logic ci,
                      input logic [W-1:0] es, input logic ec);
    int n;
    int lat;
    n = 0;
    @(negedge clk);
    while (!bus1.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    bus1.in_valid = 1'b1;
    bus1.a_in     = a;
    bus1.b_in     = b;
    bus1.cin      = ci;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    bus1.a_in     = W'($urandom);
    lat = 1;
    while (!bus1.out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check("n1_latency", lat, 3);
    check("n1_sum", bus1.sum_out, es);
    check("n1_cout", bus1.cout_out, ec);
    bus1.out_ready = 1'b1;
    @(negedge clk);
    bus1.out_ready = 1'b0;
    check("n1_post_valid", bus1.out_valid, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  initial begin
    bus0.in_valid = 1'b0; bus0.out_ready = 1'b0;
    bus0.a_in = '0; bus0.b_in = '0; bus0.cin = 1'b0;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
    bus1.a_in = '0; bus1.b_in = '0; bus1.cin = 1'b0;
`ifdef KS_SEQ_SUB_EN
    bus0.sub = 1'b0;
    bus1.sub = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    resetn = 1'b1;

    run_op(32'h00FFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h01000000, 1'b0, 4'b1110, 0);
    run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 4'b1111, 0);

    // Backpressure, then an immediate follow-up request.
    ra = $urandom; rb = $urandom; rci = 1'($urandom);
    rr = ref_add(ra, rb, rci, 1'b0);
    run_op(ra, rb, rci, 1'b0, rr[TW-1:0], rr[TW], ref_cins(ra, rb, rci, 1'b0), 5);
    ra = $urandom; rb = ~ra; rci = 1'b1;
    rr = ref_add(ra, rb, rci, 1'b0);
    run_op(ra, rb, rci, 1'b0, rr[TW-1:0], rr[TW], ref_cins(ra, rb, rci, 1'b0), 0);

    // Reset two cycles into ISSUE.
    @(negedge clk);
    bus0.in_valid = 1'b1; bus0.a_in = 32'hDEADBEEF; bus0.b_in = 32'h0F0F0F0F; bus0.cin = 1'b1;
    @(negedge clk);
    bus0.in_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check_reset_outputs("midop_reset");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    seen = 1'b0;
    repeat (N + 4) begin
      @(negedge clk);
      if (bus0.out_valid) seen = 1'b1;
    end
    check("no_valid_after_reset", seen, 1'b0);
    run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 4'b0000, 0);

    for (int i = 0; i < 20; i++) begin
      ra  = $urandom;
      rb  = (i % 3 == 0) ? ~ra : $urandom;
      rci = 1'($urandom);
`ifdef KS_SEQ_SUB_EN
      rsb = 1'($urandom);
`else
      rsb = 1'b0;
`endif
      rr = ref_add(ra, rb, rci, rsb);
      run_op(ra, rb, rci, rsb, rr[TW-1:0], rr[TW], ref_cins(ra, rb, rci, rsb), i % 4);
    end

`ifdef KS_SEQ_SUB_EN
    run_op(32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 4'b0001, 0);
    run_op(32'h00000005, 32'h00000003, 1'b0, 1'b1, 32'h00000002, 1'b1, 4'b1111, 0);
`endif

    run1(8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) begin
      sa  = W'($urandom);
      sb8 = W'($urandom);
      rci = 1'($urandom);
      sr  = {1'b0, sa} + {1'b0, sb8} + (W+1)'(rci);
      run1(sa, sb8, rci, sr[W-1:0], sr[W]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
